// File: rtl/sramx_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   vaddr_t / paddr_t : 32-bit virtual and physical byte addresses
//   tag_t             : in-flight request tag {valid, channel id, is_read}
//   KSEG_*            : segment constants used by the kseg0/kseg1 translation
package sramx_pkg;

  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] paddr_t;

  // Channel ids are stored in 3 bits so up to 8 requesters fit.
  localparam int CH_W = 3;

  // kseg0 (0x8/0x9) and kseg1 (0xA/0xB) share the top address bits 2'b10.
  localparam logic [1:0] KSEG_TOP2       = 2'b10;
  // Both segments map onto the low 512 MB of physical space.
  localparam logic [2:0] KSEG_PHYS_TOP3  = 3'b000;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
    logic            is_read;
  } tag_t;

endpackage

// File: rtl/sramx_arbiter_kseg_translate.sv
// Combinational kseg0/kseg1 virtual-to-physical address translation.
//   XLATE_EN : 1 = fold kseg0/kseg1 onto physical 0x0000_0000..0x1FFF_FFFF,
//              0 = pass the address through unmodified
//   vaddr    : virtual byte address of the granted request
//   paddr    : physical byte address driven to the SRAM port
module kseg_translate
  import sramx_pkg::*;
#(
  parameter int XLATE_EN = 1
) (
  input  vaddr_t vaddr,
  output paddr_t paddr
);

  // Clearing bits [31:29] maps 0x8/0xA -> 0x0 and 0x9/0xB -> 0x1 in one step;
  // every other segment is left alone.
  always_comb begin
    paddr = vaddr;
    if (XLATE_EN != 0 && vaddr[31:30] == KSEG_TOP2) begin
      paddr = {KSEG_PHYS_TOP3, vaddr[28:0]};
    end
  end

endmodule

// File: rtl/sramx_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM port between NUM_CH
// requesters, with a tag pipeline routing responses back to their owners.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : per-channel handshake, req_ready is a one-hot grant
//   req_addr/wen/wdata  : per-channel request payload (wen == 0 means read)
//   resp_valid/rdata    : per-channel response strobe and read data
//   sram_*              : shared SRAM port, sram_rdata arrives RD_LAT later
module sramx_arbiter
  import sramx_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int RD_LAT   = 1,
  parameter int XLATE_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH-1:0][31:0] req_addr,
  input  logic [NUM_CH-1:0][3:0]  req_wen,
  input  logic [NUM_CH-1:0][31:0] req_wdata,
  output logic [NUM_CH-1:0]       req_ready,
  output logic [NUM_CH-1:0]       resp_valid,
  output logic [NUM_CH-1:0][31:0] resp_rdata,
  output logic                    sram_en,
  output logic [3:0]              sram_wen,
  output paddr_t                  sram_addr,
  output logic [31:0]             sram_wdata,
  input  logic [31:0]             sram_rdata
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_id;
  logic              grant_found;
  vaddr_t            sel_addr;
  logic [3:0]        sel_wen;
  logic [31:0]       sel_wdata;
  tag_t              new_tag;
  tag_t              pipe [RD_LAT];

  // Round-robin search: try offsets 0..NUM_CH-1 from rr_ptr in order and grant
  // the first valid channel. Nothing is granted while reset is high.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    if (!reset) begin
      for (int off = 0; off < NUM_CH; off++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (!grant_found && req_valid[IDX_W'(k)] &&
              ((int'(rr_ptr) + off) % NUM_CH) == k) begin
            grant_found          = 1'b1;
            grant[IDX_W'(k)]     = 1'b1;
            grant_id             = CH_W'(k);
          end
        end
      end
    end
  end

  assign req_ready = grant;

  // One-hot AND-OR selection of the granted payload; all zero with no grant,
  // which also makes the translated address zero.
  always_comb begin
    sel_addr  = '0;
    sel_wen   = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[IDX_W'(k)]) begin
        sel_addr  = req_addr[IDX_W'(k)];
        sel_wen   = req_wen[IDX_W'(k)];
        sel_wdata = req_wdata[IDX_W'(k)];
      end
    end
  end

  kseg_translate #(
    .XLATE_EN (XLATE_EN)
  ) u_xlate (
    .vaddr (sel_addr),
    .paddr (sram_addr)
  );

  assign sram_en    = grant_found;
  assign sram_wen   = sel_wen;
  assign sram_wdata = sel_wdata;

  assign new_tag = '{valid: grant_found, ch: grant_id, is_read: (sel_wen == 4'h0)};

  // Pointer moves just past the accepted channel; the tag pipeline shifts
  // every cycle so a tag emerges exactly RD_LAT cycles after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= new_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
      if (grant_found) begin
        if (int'(grant_id) == NUM_CH - 1) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_id + CH_W'(1);
        end
      end
    end
  end

  // Route the emerging tag to its channel; writes get a strobe with zero data.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pipe[RD_LAT-1].valid && int'(pipe[RD_LAT-1].ch) == k) begin
        resp_valid[IDX_W'(k)] = 1'b1;
        if (pipe[RD_LAT-1].is_read) begin
          resp_rdata[IDX_W'(k)] = sram_rdata;
        end
      end
    end
  end

endmodule
